// File: rtl/seg7_pair_decoder_pkg.sv
// Shared constants for the two-digit 7-segment readback path.
// Segment patterns are active-low with bit0=a .. bit6=g.
package seg7_pair_decoder_pkg;

    localparam int SEG_W   = 7;
    localparam int PAIR_W  = 2 * SEG_W;
    localparam int DIGIT_W = 4;
    localparam int SUM_W   = 5;
    localparam int CNT_W   = 8;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h18;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCK   = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_digit_lookup.sv
// Combinational 7-segment pattern to binary digit lookup with a legal flag.
// ALLOW_BLANK lets an all-off digit read as zero (leading-blank tens digit).
module seg7_digit_lookup
    import seg7_pair_decoder_pkg::*;
#(
    parameter bit ALLOW_BLANK = 1'b0
) (
    input  logic [SEG_W-1:0]   seg,
    output logic [DIGIT_W-1:0] digit,
    output logic               legal
);

    // Pattern table; anything not listed is an illegal digit.
    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: legal = ALLOW_BLANK;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_pair_decoder.sv
// Two-digit active-low 7-segment receiver: glitch filter on the pattern pair,
// decode of a stable pair to a 4-bit value, registered status outputs.
module seg7_pair_decoder
    import seg7_pair_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_VALUE     = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic [SEG_W-1:0]   seg_ones,
    input  logic [SEG_W-1:0]   seg_tens,
    output logic [DIGIT_W-1:0] value,
    output logic               value_valid,
    output logic               update,
    output logic               pattern_err
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [SUM_W-1:0] MAX_SUM    = SUM_W'(MAX_VALUE);

    logic [PAIR_W-1:0]  in_pair_s;
    logic [PAIR_W-1:0]  pair_q, pair_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    state_e             state_q, state_d;

    logic [DIGIT_W-1:0] value_q, value_d;
    logic               value_valid_q, value_valid_d;
    logic               update_q, update_d;
    logic               pattern_err_q, pattern_err_d;

    logic [DIGIT_W-1:0] ones_digit_s, tens_digit_s;
    logic               ones_legal_s, tens_legal_s;
    logic [SUM_W-1:0]   tens_val_s, sum_s;
    logic               pair_legal_s;

    assign in_pair_s = {seg_tens, seg_ones};

    seg7_digit_lookup #(.ALLOW_BLANK(1'b0)) u_ones (
        .seg   (pair_q[SEG_W-1:0]),
        .digit (ones_digit_s),
        .legal (ones_legal_s)
    );

    seg7_digit_lookup #(.ALLOW_BLANK(1'b1)) u_tens (
        .seg   (pair_q[PAIR_W-1:SEG_W]),
        .digit (tens_digit_s),
        .legal (tens_legal_s)
    );

    // Decode of the stored pair: tens digit may only be blank, 0 or 1.
    always_comb begin
        tens_val_s   = 5'd0;
        pair_legal_s = 1'b0;
        if (tens_digit_s == 4'd1) begin
            tens_val_s = 5'd10;
        end else begin
            tens_val_s = 5'd0;
        end
        sum_s = tens_val_s + {1'b0, ones_digit_s};
        if (ones_legal_s && tens_legal_s && (tens_digit_s <= 4'd1) && (sum_s <= MAX_SUM)) begin
            pair_legal_s = 1'b1;
        end else begin
            pair_legal_s = 1'b0;
        end
    end

    // Glitch filter: a change restarts the count, equal samples count up to the threshold.
    always_comb begin
        pair_d  = pair_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (sample_en) begin
            if (in_pair_s != pair_q) begin
                pair_d = in_pair_s;
                cnt_d  = 8'd1;
                if (cnt_d >= STABLE_CNT) begin
                    state_d = LOCK;
                end else begin
                    state_d = SETTLE;
                end
            end else begin
                if (cnt_q < STABLE_CNT) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                case (state_q)
                    SETTLE: begin
                        if (cnt_d == STABLE_CNT) begin
                            state_d = LOCK;
                        end else begin
                            state_d = SETTLE;
                        end
                    end
                    LOCK:    state_d = LOCKED;
                    LOCKED:  state_d = LOCKED;
                    default: state_d = SETTLE;
                endcase
            end
        end else begin
            pair_d  = pair_q;
            cnt_d   = cnt_q;
            state_d = state_q;
        end
    end

    // Commit while in LOCK; repeating it (sample_en low) is idempotent.
    always_comb begin
        value_d       = value_q;
        value_valid_d = value_valid_q;
        pattern_err_d = pattern_err_q;
        update_d      = 1'b0;
        if (state_q == LOCK) begin
            if (pair_legal_s) begin
                value_d       = sum_s[DIGIT_W-1:0];
                value_valid_d = 1'b1;
                pattern_err_d = 1'b0;
                update_d      = (sum_s[DIGIT_W-1:0] != value_q) || !value_valid_q;
            end else begin
                value_valid_d = 1'b0;
                pattern_err_d = 1'b1;
                update_d      = 1'b0;
            end
        end else begin
            update_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q        <= {SEG_BLANK, SEG_BLANK};
            cnt_q         <= 8'd0;
            state_q       <= SETTLE;
            value_q       <= 4'd0;
            value_valid_q <= 1'b0;
            update_q      <= 1'b0;
            pattern_err_q <= 1'b0;
        end else begin
            pair_q        <= pair_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            update_q      <= update_d;
            pattern_err_q <= pattern_err_d;
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign update      = update_q;
    assign pattern_err = pattern_err_q;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Self-checking bench for seg7_pair_decoder: directed scenarios plus random
// pattern pairs, all compared against a run-length reference model.
module tb_seg7_pair_decoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic [6:0] seg_ones = 7'h7F;
    logic [6:0] seg_tens = 7'h7F;
    logic [3:0] value;
    logic       value_valid;
    logic       update;
    logic       pattern_err;

    int errors = 0;
    int checks = 0;

    int ones_tab [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h18};

    // reference model state
    logic [13:0] m_pair;
    int          m_run;
    bit          m_pending;
    logic [3:0]  m_value;
    bit          m_valid;
    bit          m_err;
    bit          m_update;
    logic        prev_upd;
    int          upd_count;

    seg7_pair_decoder #(.STABLE_CYCLES(STABLE), .MAX_VALUE(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .seg_ones    (seg_ones),
        .seg_tens    (seg_tens),
        .value       (value),
        .value_valid (value_valid),
        .update      (update),
        .pattern_err (pattern_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [13:0] p, output bit legal, output int val);
        int o;
        int t;
        o = -1;
        t = -1;
        for (int i = 0; i < 10; i++) begin
            if (int'(p[6:0]) == ones_tab[i]) o = i;
        end
        if (p[13:7] == 7'h7F || p[13:7] == 7'h40) t = 0;
        else if (p[13:7] == 7'h79) t = 10;
        legal = (o >= 0) && (t >= 0) && (o + t <= 15);
        val = legal ? o + t : 0;
    endfunction

    task automatic model_reset();
        m_pair    = 14'h3FFF;
        m_run     = 0;
        m_pending = 1'b0;
        m_value   = 4'd0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_update  = 1'b0;
        prev_upd  = 1'b0;
    endtask

    // One clock edge of the model: an accepted pair commits one edge after
    // it has been seen STABLE times in a row.
    task automatic model_edge();
        bit legal;
        int val;
        logic [13:0] p;
        m_update = 1'b0;
        if (m_pending) begin
            ref_decode(m_pair, legal, val);
            if (legal) begin
                m_update = !m_valid || (val != int'(m_value));
                m_value  = 4'(val);
                m_valid  = 1'b1;
                m_err    = 1'b0;
            end else begin
                m_valid = 1'b0;
                m_err   = 1'b1;
            end
        end
        if (sample_en) begin
            p = {seg_tens, seg_ones};
            if (p != m_pair) begin
                m_pair = p;
                m_run  = 1;
                m_pending = (m_run == STABLE);
            end else if (m_run < STABLE) begin
                m_run++;
                m_pending = (m_run == STABLE);
            end else begin
                m_pending = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("value", {4'd0, value}, {4'd0, m_value});
        check("value_valid", {7'd0, value_valid}, {7'd0, m_valid});
        check("pattern_err", {7'd0, pattern_err}, {7'd0, m_err});
        check("update", {7'd0, update}, {7'd0, m_update});
        check("update_b2b", {7'd0, update & prev_upd}, 8'd0);
        prev_upd = update;
        if (update) upd_count++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic [6:0] t, input logic [6:0] o);
        seg_tens = t;
        seg_ones = o;
    endtask

    initial begin
        model_reset();
        upd_count = 0;
        #2;
        check("rst_value", {4'd0, value}, 8'd0);
        check("rst_valid", {7'd0, value_valid}, 8'd0);
        check("rst_update", {7'd0, update}, 8'd0);
        check("rst_err", {7'd0, pattern_err}, 8'd0);
        #10 rst_n = 1'b1;

        // 3 with blank tens
        sample_en = 1'b1;
        drive(7'h7F, 7'h30);
        run(4);
        check("a_pre_valid", {7'd0, value_valid}, 8'd0);
        run(1);
        check("a_update", {7'd0, update}, 8'd1);
        check("a_value", {4'd0, value}, 8'd3);
        check("a_valid", {7'd0, value_valid}, 8'd1);
        check("a_err", {7'd0, pattern_err}, 8'd0);

        // 15 = tens "1" + ones "5"
        drive(7'h79, 7'h12);
        run(4);
        check("b_hold3", {4'd0, value}, 8'd3);
        run(1);
        check("b_update", {7'd0, update}, 8'd1);
        check("b_value", {4'd0, value}, 8'd15);
        upd_count = 0;
        run(20);
        check("b_no_more_upd", 8'(upd_count), 8'd0);

        // glitch to 19 shorter than the threshold, then stable 19
        drive(7'h7F, 7'h78);
        run(6);
        check("c_value7", {4'd0, value}, 8'd7);
        upd_count = 0;
        drive(7'h79, 7'h18);
        run(2);
        drive(7'h7F, 7'h78);
        run(8);
        check("c_glitch_upd", 8'(upd_count), 8'd0);
        check("c_glitch_val", {4'd0, value}, 8'd7);
        check("c_glitch_vld", {7'd0, value_valid}, 8'd1);
        drive(7'h79, 7'h18);
        run(6);
        check("c_err19", {7'd0, pattern_err}, 8'd1);
        check("c_vld19", {7'd0, value_valid}, 8'd0);
        check("c_hold19", {4'd0, value}, 8'd7);

        // blank ones is illegal, then "0"
        drive(7'h7F, 7'h7F);
        run(6);
        check("d_err_blank", {7'd0, pattern_err}, 8'd1);
        drive(7'h7F, 7'h40);
        run(5);
        check("d_update0", {7'd0, update}, 8'd1);
        check("d_value0", {4'd0, value}, 8'd0);
        check("d_valid0", {7'd0, value_valid}, 8'd1);

        // sample_en low hides a 3 -> 9 change
        drive(7'h7F, 7'h30);
        run(6);
        sample_en = 1'b0;
        drive(7'h7F, 7'h18);
        run(6);
        check("e_hidden", {4'd0, value}, 8'd3);
        sample_en = 1'b1;
        run(4);
        check("e_not_yet", {4'd0, value}, 8'd3);
        run(1);
        check("e_update9", {7'd0, update}, 8'd1);
        check("e_value9", {4'd0, value}, 8'd9);

        // asynchronous reset mid-settle, then first lock of 0 must pulse
        drive(7'h79, 7'h40);
        run(2);
        #1 rst_n = 1'b0;
        #1;
        check("f_rst_value", {4'd0, value}, 8'd0);
        check("f_rst_valid", {7'd0, value_valid}, 8'd0);
        check("f_rst_err", {7'd0, pattern_err}, 8'd0);
        check("f_rst_update", {7'd0, update}, 8'd0);
        model_reset();
        #1 rst_n = 1'b1;
        drive(7'h7F, 7'h40);
        run(5);
        check("f_first_upd", {7'd0, update}, 8'd1);
        check("f_first_val", {4'd0, value}, 8'd0);

        // random pairs held 1..8 cycles
        for (int k = 0; k < 300; k++) begin
            int o;
            int t;
            logic [6:0] tp;
            logic [6:0] op;
            o = int'($urandom_range(9));
            t = int'($urandom_range(2));
            op = 7'(ones_tab[o]);
            tp = (t == 0) ? 7'h7F : ((t == 1) ? 7'h40 : 7'h79);
            if ($urandom_range(7) == 0) op = 7'($urandom_range(127));
            drive(tp, op);
            run(int'($urandom_range(8, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
